// File: rtl/risc_proc_pkg.sv
// Shared definitions for the RISC_PROC fetch front end.
//   NOP_INSTR     : encoding placed in IF/ID when it holds no real instruction
//   PC_W          : program-counter / instruction width
//   fetch_state_t : fetch FSM states
//   pc_add        : modulo-2^PC_W address increment helper
package risc_proc_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // no request outstanding
        WAIT  = 2'd1,   // request outstanding, result wanted
        HOLD  = 2'd2,   // fetched word parked while decode is stalled
        REDIR = 2'd3    // outstanding request belongs to the wrong path
    } fetch_state_t;

    // Width-preserving add; the carry out is dropped so 16'hFFFF wraps to 16'h0000.
    function automatic logic [PC_W-1:0] pc_add(
        input logic [PC_W-1:0] base,
        input logic [PC_W-1:0] inc
    );
        return base + inc;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry parking register for a fetched instruction and its address.
// Used when memory returns data while decode is stalled.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture load_instr/load_addr and mark the entry valid
//   clear        : empty the entry (wins over load)
//   load_instr   : instruction word to park
//   load_addr    : address of that instruction
//   hold_valid   : entry holds a real instruction
//   hold_instr   : parked instruction (NOP when empty after reset/clear)
//   hold_addr    : parked address
module fetch_hold_buf
    import risc_proc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [PC_W-1:0] load_instr,
    input  logic [PC_W-1:0] load_addr,
    output logic            hold_valid,
    output logic [PC_W-1:0] hold_instr,
    output logic [PC_W-1:0] hold_addr
);

    logic            valid_r;
    logic [PC_W-1:0] instr_r;
    logic [PC_W-1:0] addr_r;

    // Entry register: clear has priority so a redirect always empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            addr_r  <= 16'h0000;
        end else if (clear) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            addr_r  <= 16'h0000;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            addr_r  <= load_addr;
        end else begin
            valid_r <= valid_r;
            instr_r <= instr_r;
            addr_r  <= addr_r;
        end
    end

    assign hold_valid = valid_r;
    assign hold_instr = instr_r;
    assign hold_addr  = addr_r;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory
// requests, loads the IF/ID register, and applies branch redirects and
// hazard stalls. All outputs come straight from flops.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pcsrc           : redirect request (taken branch)
//   pcsrc2          : redirect resolved in EXE, also flush ID/EXE
//   bra_pc          : redirect target
//   stall           : hazard stall, freezes PC and IF/ID
//   imem_req        : fetch request, held until imem_ack
//   imem_addr       : fetch address, stable while imem_req
//   imem_ack        : one-cycle completion pulse, imem_data valid with it
//   imem_data       : fetched instruction
//   ifid_valid      : IF/ID holds a real instruction
//   ifid_instr      : instruction to decode (NOP when invalid)
//   ifid_pc         : address of ifid_instr
//   ifid_flush      : one-cycle IF/ID flush pulse
//   idexe_flush     : one-cycle ID/EXE flush pulse
module pc_fetch_unit
    import risc_proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_INC   = 16'd1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            pcsrc,
    input  logic            pcsrc2,
    input  logic [PC_W-1:0] bra_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_data,
    output logic            ifid_valid,
    output logic [PC_W-1:0] ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic            ifid_flush,
    output logic            idexe_flush
);

    fetch_state_t    state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic            req_r, req_s;
    logic [PC_W-1:0] addr_r, addr_s;
    logic            valid_r, valid_s;
    logic [PC_W-1:0] instr_r, instr_s;
    logic [PC_W-1:0] ifpc_r, ifpc_s;
    logic            ifid_flush_r, ifid_flush_s;
    logic            idexe_flush_r, idexe_flush_s;

    logic            hb_load_s;
    logic            hb_clear_s;
    logic            hb_valid_s;
    logic [PC_W-1:0] hb_instr_s;
    logic [PC_W-1:0] hb_addr_s;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (hb_load_s),
        .clear      (hb_clear_s),
        .load_instr (imem_data),
        .load_addr  (addr_r),
        .hold_valid (hb_valid_s),
        .hold_instr (hb_instr_s),
        .hold_addr  (hb_addr_s)
    );

    // Next-state and next-output logic; a redirect outranks stall and every state.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        req_s         = req_r;
        addr_s        = addr_r;
        valid_s       = valid_r;
        instr_s       = instr_r;
        ifpc_s        = ifpc_r;
        ifid_flush_s  = 1'b0;
        idexe_flush_s = 1'b0;
        hb_load_s     = 1'b0;
        hb_clear_s    = 1'b0;

        if (pcsrc) begin
            pc_s          = bra_pc;
            ifid_flush_s  = 1'b1;
            idexe_flush_s = pcsrc2;
            valid_s       = 1'b0;
            instr_s       = NOP_INSTR;
            hb_clear_s    = 1'b1;
            if (((state_r == WAIT) || (state_r == REDIR)) && !imem_ack) begin
                // The in-flight request cannot be aborted: keep it on the bus
                // and throw its data away when it completes.
                state_s = REDIR;
            end else begin
                req_s   = 1'b1;
                addr_s  = bra_pc;
                state_s = WAIT;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (!stall) begin
                        req_s   = 1'b1;
                        addr_s  = pc_r;
                        state_s = WAIT;
                    end else begin
                        state_s = RUN;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            valid_s = 1'b1;
                            instr_s = imem_data;
                            ifpc_s  = addr_r;
                            pc_s    = pc_add(addr_r, PC_INC);
                            addr_s  = pc_add(addr_r, PC_INC);
                            req_s   = 1'b1;
                            state_s = WAIT;
                        end else begin
                            hb_load_s = 1'b1;
                            req_s     = 1'b0;
                            state_s   = HOLD;
                        end
                    end else if (!stall) begin
                        // Memory still busy: decode sees a bubble.
                        valid_s = 1'b0;
                        instr_s = NOP_INSTR;
                    end else begin
                        state_s = WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_s    = hb_valid_s;
                        instr_s    = hb_instr_s;
                        ifpc_s     = hb_addr_s;
                        pc_s       = pc_add(hb_addr_s, PC_INC);
                        addr_s     = pc_add(hb_addr_s, PC_INC);
                        req_s      = 1'b1;
                        hb_clear_s = 1'b1;
                        state_s    = WAIT;
                    end else begin
                        state_s = HOLD;
                    end
                end
                REDIR: begin
                    if (imem_ack) begin
                        // Stale data dropped; pc already holds the target.
                        req_s   = 1'b1;
                        addr_s  = pc_r;
                        state_s = WAIT;
                    end else begin
                        state_s = REDIR;
                    end
                end
                default: begin
                    state_s = RUN;
                    req_s   = 1'b0;
                end
            endcase
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            req_r         <= 1'b0;
            addr_r        <= RESET_PC;
            valid_r       <= 1'b0;
            instr_r       <= NOP_INSTR;
            ifpc_r        <= 16'h0000;
            ifid_flush_r  <= 1'b0;
            idexe_flush_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            req_r         <= req_s;
            addr_r        <= addr_s;
            valid_r       <= valid_s;
            instr_r       <= instr_s;
            ifpc_r        <= ifpc_s;
            ifid_flush_r  <= ifid_flush_s;
            idexe_flush_r <= idexe_flush_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign ifid_valid  = valid_r;
    assign ifid_instr  = instr_r;
    assign ifid_pc     = ifpc_r;
    assign ifid_flush  = ifid_flush_r;
    assign idexe_flush = idexe_flush_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsrc;
    logic        pcsrc2;
    logic [15:0] bra_pc;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_flush;
    logic        idexe_flush;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pcsrc       (pcsrc),
        .pcsrc2      (pcsrc2),
        .bra_pc      (bra_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_flush  (ifid_flush),
        .idexe_flush (idexe_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_req"},   imem_req,    1'b0);
        chk ({tag, "_addr"},  imem_addr,   16'h0000);
        chk1({tag, "_valid"}, ifid_valid,  1'b0);
        chk ({tag, "_instr"}, ifid_instr,  16'h0000);
        chk ({tag, "_pc"},    ifid_pc,     16'h0000);
        chk1({tag, "_ifl"},   ifid_flush,  1'b0);
        chk1({tag, "_efl"},   idexe_flush, 1'b0);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] pc);
        chk1({tag, "_valid"}, ifid_valid, v);
        chk ({tag, "_instr"}, ifid_instr, ins);
        chk ({tag, "_pc"},    ifid_pc,    pc);
    endtask

    // One cycle with an ack carrying data (optionally with a redirect).
    task automatic ack_cycle(input logic [15:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; pcsrc = 1'b0; pcsrc2 = 1'b0; bra_pc = 16'h0000;
        stall = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
        tick(); tick();
        chk_reset("rst0");

        // Straight-line fetch, ack in the second cycle of each request.
        rst = 1'b0;
        tick();
        chk1("sl_req0", imem_req, 1'b1);
        chk("sl_addr0", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("sl_bubble", ifid_valid, 1'b0);
            chk("sl_addr_hold", imem_addr, 16'(i));
            ack_cycle(16'h1000 + 16'(i));
            chk_ifid("sl_fetch", 1'b1, 16'h1000 + 16'(i), 16'(i));
            chk("sl_next_addr", imem_addr, 16'(i + 1));
            chk1("sl_req", imem_req, 1'b1);
        end

        // Redirect with no request outstanding (RUN held by stall).
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b1;
        tick();
        chk1("run_stall_req", imem_req, 1'b0);
        pcsrc = 1'b1; bra_pc = 16'h0040;
        tick();
        pcsrc = 1'b0;
        chk1("r0_ifl", ifid_flush, 1'b1);
        chk1("r0_efl", idexe_flush, 1'b0);
        chk1("r0_req", imem_req, 1'b1);
        chk("r0_addr", imem_addr, 16'h0040);
        tick();
        chk1("r0_ifl_off", ifid_flush, 1'b0);
        stall = 1'b0;

        // Redirect coinciding with the ack: data dropped, target next cycle.
        pcsrc = 1'b1; bra_pc = 16'h0005;
        ack_cycle(16'hBEEF);
        pcsrc = 1'b0;
        chk("ra_addr", imem_addr, 16'h0005);
        chk_ifid("ra_drop", 1'b0, 16'h0000, 16'h0000);
        chk1("ra_ifl", ifid_flush, 1'b1);

        // Redirect mid-request with EXE resolution.
        tick();
        pcsrc = 1'b1; pcsrc2 = 1'b1; bra_pc = 16'h0100;
        tick();
        pcsrc = 1'b0; pcsrc2 = 1'b0;
        chk1("rm_ifl", ifid_flush, 1'b1);
        chk1("rm_efl", idexe_flush, 1'b1);
        chk("rm_addr_kept", imem_addr, 16'h0005);
        chk1("rm_req_kept", imem_req, 1'b1);
        tick();
        chk1("rm_ifl_off", ifid_flush, 1'b0);
        chk1("rm_efl_off", idexe_flush, 1'b0);
        tick();
        ack_cycle(16'hDEAD);
        chk1("rm_stale_valid", ifid_valid, 1'b0);
        chk("rm_stale_instr", ifid_instr, 16'h0000);
        chk("rm_target_addr", imem_addr, 16'h0100);
        chk1("rm_target_req", imem_req, 1'b1);
        chk1("rm_no_reflush", ifid_flush, 1'b0);
        tick();
        ack_cycle(16'h2100);
        chk_ifid("rm_fetch", 1'b1, 16'h2100, 16'h0100);
        chk("rm_next_addr", imem_addr, 16'h0101);

        // Stall at ack: reach 0x000F via redirect, fetch it, then stall on 0x0010.
        tick();
        pcsrc = 1'b1; bra_pc = 16'h000F;
        ack_cycle(16'h0BAD);
        pcsrc = 1'b0;
        tick();
        ack_cycle(16'h300F);
        chk_ifid("st_pre", 1'b1, 16'h300F, 16'h000F);
        chk("st_addr", imem_addr, 16'h0010);
        stall = 1'b1;
        tick();
        chk_ifid("st_wait_hold", 1'b1, 16'h300F, 16'h000F);
        ack_cycle(16'h3010);
        chk1("st_req_drop", imem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("st_frozen", 1'b1, 16'h300F, 16'h000F);
            chk1("st_req_off", imem_req, 1'b0);
        end
        stall = 1'b0;
        tick();
        chk_ifid("st_release", 1'b1, 16'h3010, 16'h0010);
        chk1("st_req_on", imem_req, 1'b1);
        chk("st_next_addr", imem_addr, 16'h0011);

        // Redirect beats stall while in HOLD.
        tick();
        stall = 1'b1;
        ack_cycle(16'h3011);
        chk1("rh_hold_req", imem_req, 1'b0);
        pcsrc = 1'b1; bra_pc = 16'h0200;
        tick();
        pcsrc = 1'b0; stall = 1'b0;
        chk("rh_addr", imem_addr, 16'h0200);
        chk1("rh_req", imem_req, 1'b1);
        chk1("rh_ifl", ifid_flush, 1'b1);
        chk1("rh_valid", ifid_valid, 1'b0);
        tick();
        chk1("rh_no_holdbuf", ifid_valid, 1'b0);
        ack_cycle(16'h4200);
        chk_ifid("rh_fetch", 1'b1, 16'h4200, 16'h0200);

        // Wrap from 0xFFFF, then reset mid-request and a late ack.
        tick();
        pcsrc = 1'b1; bra_pc = 16'hFFFF;
        ack_cycle(16'h0BAD);
        pcsrc = 1'b0;
        chk("wr_addr", imem_addr, 16'hFFFF);
        tick();
        ack_cycle(16'h5FFF);
        chk_ifid("wr_fetch", 1'b1, 16'h5FFF, 16'hFFFF);
        chk("wr_wrap_addr", imem_addr, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        rst = 1'b0;
        ack_cycle(16'h6666);
        chk1("late_ack_valid", ifid_valid, 1'b0);
        chk("late_ack_instr", ifid_instr, 16'h0000);
        chk1("late_ack_req", imem_req, 1'b1);
        chk("late_ack_addr", imem_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
